// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Write-side valid/ready handshake into the buffered UART
//                transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 wr_valid;
   logic [DATA_BITS-1:0] wr_data;
   logic                 wr_ready;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : FIFO-buffered UART transmitter: start, DATA_BITS data bits
//                LSB first, optional even parity (UART_PARITY_EN), STOP_BITS.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int CLK_HZ     = 125000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  wire logic                              sysclk_i,
   input  wire logic                              reset_btn_i,
   uart_tx_fifo_if.slave                          wr_if,
   output logic                                   uart_tx_o,
   output logic                                   busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count_o,
   output logic                                   tx_done_o
);

   localparam int c_div    = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int c_bcnt_w = (c_div > 2) ? $clog2(c_div) : 1;
   localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
   localparam int c_fcnt_w = $clog2(FIFO_DEPTH + 1);
   localparam int c_idx_w  = $clog2(DATA_BITS);

   localparam logic [c_bcnt_w-1:0] c_reload   = c_bcnt_w'(c_div - 1);
   localparam logic [c_fcnt_w-1:0] c_full     = c_fcnt_w'(FIFO_DEPTH);
   localparam logic [c_idx_w-1:0]  c_last_bit = c_idx_w'(DATA_BITS - 1);
   localparam logic [c_idx_w-1:0]  c_last_stp = c_idx_w'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
   logic [c_fcnt_w-1:0]  count_q, count_d;
   logic                 w_push, w_pop, w_full, w_empty;
   logic [DATA_BITS-1:0] w_head;

   assign w_full  = (count_q == c_full);
   assign w_empty = (count_q == '0);
   assign w_push  = wr_if.wr_valid && !w_full;
   assign w_head  = mem[rd_ptr_q];

   always_ff @(posedge sysclk_i) begin
      if (w_push) begin
         mem[wr_ptr_q] <= wr_if.wr_data;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge sysclk_i or posedge reset_btn_i) begin
      if (reset_btn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Framing FSM
   // ------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [c_bcnt_w-1:0]  bcnt_q, bcnt_d;
   logic [c_idx_w-1:0]   idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 w_bit_end;
`ifdef UART_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign w_bit_end = (bcnt_q == '0);

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      w_pop   = 1'b0;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop   = 1'b1;
               shift_d = w_head;
`ifdef UART_PARITY_EN
               par_d   = ^w_head;
`endif
               bcnt_d  = c_reload;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               bcnt_d  = c_reload;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               bcnt_d = bcnt_q - 1'b1;
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               bcnt_d = c_reload;
               if (idx_q == c_last_bit) begin
`ifdef UART_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  idx_d   = '0;
                  state_d = S_STOP;
`endif
               end else begin
                  // Line bit is taken from position 1 before the shift lands.
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               bcnt_d = bcnt_q - 1'b1;
            end
         end

`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               bcnt_d  = c_reload;
               idx_d   = '0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               bcnt_d = bcnt_q - 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (w_bit_end) begin
               bcnt_d = c_reload;
               if (idx_q == c_last_stp) begin
                  done_d = 1'b1;
                  // Chain straight into the next frame with no idle gap.
                  if (!w_empty) begin
                     w_pop   = 1'b1;
                     shift_d = w_head;
`ifdef UART_PARITY_EN
                     par_d   = ^w_head;
`endif
                     tx_d    = 1'b0;
                     state_d = S_START;
                  end else begin
                     bcnt_d  = '0;
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q - 1'b1;
            end
         end

         default: begin
            bcnt_d  = '0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysclk_i or posedge reset_btn_i) begin
      if (reset_btn_i) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign wr_if.wr_ready = !w_full;
   assign uart_tx_o      = tx_q;
   assign busy_o         = (state_q != S_IDLE) || !w_empty;
   assign fifo_count_o   = count_q;
   assign tx_done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo (DIV=16);
//                parity frames are expected when UART_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int DIV    = 16;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();

   logic       tx_a, busy_a, done_a;
   logic [2:0] cnt_a;
   logic       tx_b, busy_b, done_b;
   logic [1:0] cnt_b;

   uart_tx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dut_a (
      .sysclk_i(clk), .reset_btn_i(rst), .wr_if(if_a),
      .uart_tx_o(tx_a), .busy_o(busy_a), .fifo_count_o(cnt_a), .tx_done_o(done_a)
   );

   uart_tx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(2)
   ) dut_b (
      .sysclk_i(clk), .reset_btn_i(rst), .wr_if(if_b),
      .uart_tx_o(tx_b), .busy_o(busy_b), .fifo_count_o(cnt_b), .tx_done_o(done_b)
   );

   int checks   = 0;
   int failures = 0;
   int ndone_a  = 0;
   int ndone_b  = 0;

   always @(posedge clk) begin
      if (done_a === 1'b1) ndone_a <= ndone_a + 1;
      if (done_b === 1'b1) ndone_b <= ndone_b + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Line image LSB first: start, data, optional even parity, stop ones above.
   function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nd);
      logic [15:0] f;
      logic        p;
      f = '1;
      f[0] = 1'b0;
      p = 1'b0;
      for (int i = 0; i < nd; i++) begin
         f[1+i] = d[i];
         p      = p ^ d[i];
      end
      if (PB == 1) f[1+nd] = p;
      return f;
   endfunction

   function automatic int flen(input int nd, input int ns);
      return 1 + nd + PB + ns;
   endfunction

   // Starts on a line-sample cycle; skip = cycles of bit 0 already elapsed.
   task automatic frame(input bit sel, input logic [15:0] bits, input int nb,
                        input int skip, input string tag);
      for (int b = 0; b < nb; b++) begin
         logic obs;
         obs = bits[b];
         for (int c = ((b == 0) ? skip : 0); c < DIV; c++) begin
            logic line;
            line = sel ? tx_b : tx_a;
            if (line !== bits[b]) obs = line;
            tick(1);
         end
         chk($sformatf("%s_bit%0d", tag, b), {31'b0, obs}, {31'b0, bits[b]});
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int lows;

      rst           = 1'b1;
      if_a.wr_valid = 1'b0;
      if_a.wr_data  = '0;
      if_b.wr_valid = 1'b0;
      if_b.wr_data  = '0;
      tick(3);

      chk("rst_tx",       {31'b0, tx_a},            1);
      chk("rst_wr_ready", {31'b0, if_a.wr_ready},   1);
      chk("rst_busy",     {31'b0, busy_a},          0);
      chk("rst_count",    {29'b0, cnt_a},           0);
      chk("rst_done",     {31'b0, done_a},          0);
      rst = 1'b0;
      tick(2);
      chk("post_rst_tx",  {31'b0, tx_a},            1);

      // Single 0x55 frame: latency, bit timing, tx_done position, busy drop.
      base = ndone_a;
      if_a.wr_valid = 1'b1;
      if_a.wr_data  = 8'h55;
      tick(1);
      if_a.wr_valid = 1'b0;
      chk("t1_count_after_write", {29'b0, cnt_a}, 1);
      chk("t1_tx_idle_at_write",  {31'b0, tx_a},  1);
      tick(1);
      chk("t1_popped",  {29'b0, cnt_a},  0);
      chk("t1_busy",    {31'b0, busy_a}, 1);
      frame(1'b0, mk_frame(9'h55, 8), flen(8, 1), 0, "t1");
      chk("t1_done_pulse", {31'b0, done_a}, 1);
      tick(1);
      chk("t1_done_one_cycle", {31'b0, done_a}, 0);
      chk("t1_busy_low",       {31'b0, busy_a}, 0);
      chk("t1_done_count",     ndone_a - base,  1);

      // Three back-to-back frames.
      base = ndone_a;
      if_a.wr_valid = 1'b1;
      if_a.wr_data  = 8'hA1;
      tick(1);
      if_a.wr_data  = 8'h00;
      tick(1);
      chk("t2_start_low", {31'b0, tx_a}, 0);
      if_a.wr_data  = 8'hFF;
      tick(1);
      if_a.wr_valid = 1'b0;
      chk("t2_count_peak", {29'b0, cnt_a}, 2);
      frame(1'b0, mk_frame(9'hA1, 8), flen(8, 1), 1, "t2a");
      frame(1'b0, mk_frame(9'h00, 8), flen(8, 1), 0, "t2b");
      frame(1'b0, mk_frame(9'hFF, 8), flen(8, 1), 0, "t2c");
      tick(20);
      chk("t2_done_count", ndone_a - base,  3);
      chk("t2_idle_tx",    {31'b0, tx_a},   1);
      chk("t2_idle_busy",  {31'b0, busy_a}, 0);

      // Overflow: depth 4, eight offered, 1..5 accepted, 6..8 dropped.
      base = ndone_a;
      if_a.wr_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if_a.wr_data = 8'(i);
         tick(1);
         if (i == 5) begin
            chk("t3_count_full", {29'b0, cnt_a},          4);
            chk("t3_ready_low",  {31'b0, if_a.wr_ready},  0);
         end
      end
      if_a.wr_valid = 1'b0;
      chk("t3_count_after_drops", {29'b0, cnt_a}, 4);
      frame(1'b0, mk_frame(9'h01, 8), flen(8, 1), 6, "t3_1");
      frame(1'b0, mk_frame(9'h02, 8), flen(8, 1), 0, "t3_2");
      frame(1'b0, mk_frame(9'h03, 8), flen(8, 1), 0, "t3_3");
      frame(1'b0, mk_frame(9'h04, 8), flen(8, 1), 0, "t3_4");
      frame(1'b0, mk_frame(9'h05, 8), flen(8, 1), 0, "t3_5");
      lows = 0;
      for (int c = 0; c < 48; c++) begin
         if (tx_a !== 1'b1) lows++;
         tick(1);
      end
      chk("t3_no_extra_frame", lows,           0);
      chk("t3_done_count",     ndone_a - base, 5);
      chk("t3_count_empty",    {29'b0, cnt_a}, 0);

      // 7 data bits, 2 stop bits: 32-cycle stop before tx_done.
      base = ndone_b;
      if_b.wr_valid = 1'b1;
      if_b.wr_data  = 7'h7F;
      tick(1);
      if_b.wr_valid = 1'b0;
      tick(1);
      frame(1'b1, mk_frame(9'h7F, 7), flen(7, 2), 0, "t4");
      chk("t4_done_pulse", {31'b0, done_b}, 1);
      tick(1);
      chk("t4_done_count", ndone_b - base,  1);
      chk("t4_busy_low",   {31'b0, busy_b}, 0);

      // Reset in the middle of a data bit with three bytes queued.
      base = ndone_a;
      if_a.wr_valid = 1'b1;
      if_a.wr_data  = 8'h11; tick(1);
      if_a.wr_data  = 8'h22; tick(1);
      if_a.wr_data  = 8'h33; tick(1);
      if_a.wr_data  = 8'h44; tick(1);
      if_a.wr_valid = 1'b0;
      chk("t5_queued", {29'b0, cnt_a}, 3);
      tick(40);
      chk("t5_busy_mid_frame", {31'b0, busy_a}, 1);
      rst = 1'b1;
      #1;
      chk("t5_tx_async_high", {31'b0, tx_a},          1);
      chk("t5_count_cleared", {29'b0, cnt_a},         0);
      chk("t5_busy_cleared",  {31'b0, busy_a},        0);
      chk("t5_ready_high",    {31'b0, if_a.wr_ready}, 1);
      tick(1);
      rst = 1'b0;
      lows = 0;
      for (int c = 0; c < 400; c++) begin
         if (tx_a !== 1'b1) lows++;
         tick(1);
      end
      chk("t5_line_idle",     lows,           0);
      chk("t5_no_done",       ndone_a - base, 0);
      chk("t5_still_empty",   {29'b0, cnt_a}, 0);

`ifdef UART_PARITY_EN
      // Even parity: 0x07 -> 1, 0x03 -> 0; 176-cycle frames.
      if_a.wr_valid = 1'b1;
      if_a.wr_data  = 8'h07;
      tick(1);
      if_a.wr_valid = 1'b0;
      tick(1);
      frame(1'b0, 16'hFE0E, 11, 0, "tp07");
      chk("tp07_done", {31'b0, done_a}, 1);
      tick(2);
      if_a.wr_valid = 1'b1;
      if_a.wr_data  = 8'h03;
      tick(1);
      if_a.wr_valid = 1'b0;
      tick(1);
      frame(1'b0, 16'hFC06, 11, 0, "tp03");
      chk("tp03_done", {31'b0, done_a}, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
